// File: rtl/wb_uart_fifo_pkg.sv
// Shared register map, STATUS/CTRL bit positions and shifter state encodings for wb_uart_fifo.
package wb_uart_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_RXOVR    = 5;
  localparam int ST_FERR     = 6;
  localparam int ST_TXOVF    = 7;

  localparam int CTRL_IE_RX     = 0;
  localparam int CTRL_IE_TX     = 1;
  localparam int CTRL_CLR_RXOVR = 5;
  localparam int CTRL_CLR_FERR  = 6;
  localparam int CTRL_CLR_TXOVF = 7;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; push into a full FIFO succeeds only when a pop happens the same cycle.
// Latency: one cycle push-to-visible; backpressure: none, callers see full/empty and excess pushes are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_uart_fifo.sv
// Wishbone 8N1 UART with TX/RX FIFOs, runtime baud divisor, sticky error flags and a registered level irq.
// Latency: ack one cycle after request; backpressure: none, full TX FIFO drops writes, full RX FIFO drops bytes.
module wb_uart_fifo
  import wb_uart_fifo_pkg::*;
#(
  parameter int                   FIFO_DEPTH = 8,
  parameter int                   DIV_WIDTH  = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET  = 16'd104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  logic                 req, data_wr, data_rd, div_wr, ctrl_wr;
  logic [1:0]           addr;
  logic [31:0]          rdata;
  logic [7:0]           status;
  logic [DIV_WIDTH-1:0] div_q, div_eff;
  logic                 ie_rx, ie_tx, rxovr, ferr, txovf;
  logic                 rxovr_set, ferr_set, txovf_set;

  logic       tx_empty, tx_full, rx_empty, rx_full, tx_busy;
  logic [7:0] tx_dout, rx_dout;

  tx_state_t            tx_state, tx_state_nxt;
  logic [DIV_WIDTH-1:0] tx_cnt, tx_div;
  logic [2:0]           tx_bit;
  logic [7:0]           tx_shift;
  logic                 tx_load, tx_tick, tx_shift_en;

  rx_state_t            rx_state, rx_state_nxt;
  logic [DIV_WIDTH-1:0] rx_cnt, rx_div;
  logic [2:0]           rx_bit;
  logic [7:0]           rx_shift;
  logic                 rx_meta, rx_sync, rx_prev;
  logic                 rx_start, rx_half_tick, rx_full_tick, rx_cnt_clr, rx_shift_en, rx_push;

  logic unused_ok;
  assign unused_ok = ^{adr_i[15:4], adr_i[1:0], sel_i[3:1], dat_i[31:8]};

  assign req     = stb_i & cyc_i & ~ack_o;
  assign addr    = adr_i[3:2];
  assign data_wr = req &  we_i & sel_i[0] & (addr == REG_DATA);
  assign data_rd = req & ~we_i & sel_i[0] & (addr == REG_DATA);
  assign div_wr  = req &  we_i & sel_i[0] & (addr == REG_DIV);
  assign ctrl_wr = req &  we_i & sel_i[0] & (addr == REG_CTRL);
  assign div_eff = (div_q < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_q;
  assign tx_busy = (tx_state != TX_IDLE);

  assign status = {txovf, ferr, rxovr, tx_busy, tx_full, tx_empty, rx_full, rx_empty};

  always_comb begin
    rdata = '0;
    case (addr)
      REG_DATA:   if (!rx_empty) rdata[7:0] = rx_dout;
      REG_STATUS: rdata[7:0] = status;
      REG_DIV:    rdata[DIV_WIDTH-1:0] = div_q;
      REG_CTRL:   rdata[1:0] = {ie_tx, ie_rx};
      default:    rdata = '0;
    endcase
  end

  // A same-cycle pop frees the slot, so only a push without a pop overflows.
  assign txovf_set = data_wr & tx_full & ~tx_load;
  assign rxovr_set = rx_push & rx_full & ~data_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_o <= 1'b0;
      dat_o <= '0;
      div_q <= DIV_RESET;
      ie_rx <= 1'b0;
      ie_tx <= 1'b0;
      rxovr <= 1'b0;
      ferr  <= 1'b0;
      txovf <= 1'b0;
      irq   <= 1'b0;
    end else begin
      ack_o <= req;
      if (req && !we_i) dat_o <= rdata;
      if (div_wr) div_q <= dat_i[DIV_WIDTH-1:0];
      if (ctrl_wr) begin
        ie_rx <= dat_i[CTRL_IE_RX];
        ie_tx <= dat_i[CTRL_IE_TX];
      end
      rxovr <= (rxovr | rxovr_set) & ~(ctrl_wr & dat_i[CTRL_CLR_RXOVR]);
      ferr  <= (ferr  | ferr_set)  & ~(ctrl_wr & dat_i[CTRL_CLR_FERR]);
      txovf <= (txovf | txovf_set) & ~(ctrl_wr & dat_i[CTRL_CLR_TXOVF]);
      irq   <= (ie_rx & ~rx_empty) | (ie_tx & tx_empty & ~tx_busy);
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(data_wr), .pop(tx_load), .din(dat_i[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(data_rd), .din(rx_shift),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  assign tx_tick = (tx_cnt == tx_div - DIV_WIDTH'(1));

  // STOP chains straight into the next START so queued frames leave with no idle gap.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_load      = 1'b0;
    tx_shift_en  = 1'b0;
    case (tx_state)
      TX_IDLE: if (!tx_empty) begin
        tx_load      = 1'b1;
        tx_state_nxt = TX_START;
      end
      TX_START: if (tx_tick) tx_state_nxt = TX_DATA;
      TX_DATA: if (tx_tick) begin
        tx_shift_en = 1'b1;
        if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
      end
      TX_STOP: if (tx_tick) begin
        if (!tx_empty) begin
          tx_load      = 1'b1;
          tx_state_nxt = TX_START;
        end else begin
          tx_state_nxt = TX_IDLE;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = tx_shift[0];
      default:  tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= DIV_RESET;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_load) begin
        tx_shift <= tx_dout;
        tx_div   <= div_eff;
        tx_bit   <= '0;
      end else if (tx_shift_en) begin
        tx_shift <= {1'b1, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
      if (tx_load || tx_tick || tx_state == TX_IDLE) tx_cnt <= '0;
      else                                           tx_cnt <= tx_cnt + DIV_WIDTH'(1);
    end
  end

  assign rx_half_tick = (rx_cnt == (rx_div >> 1) - DIV_WIDTH'(1));
  assign rx_full_tick = (rx_cnt == rx_div - DIV_WIDTH'(1));

  always_comb begin
    rx_state_nxt = rx_state;
    rx_start     = 1'b0;
    rx_cnt_clr   = 1'b0;
    rx_shift_en  = 1'b0;
    rx_push      = 1'b0;
    ferr_set     = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_sync) begin
        rx_start     = 1'b1;
        rx_state_nxt = RX_START;
      end
      RX_START: if (rx_half_tick) begin
        rx_cnt_clr   = 1'b1;
        rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_full_tick) begin
        rx_cnt_clr  = 1'b1;
        rx_shift_en = 1'b1;
        if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
      end
      RX_STOP: if (rx_full_tick) begin
        rx_cnt_clr   = 1'b1;
        rx_push      = rx_sync;
        ferr_set     = ~rx_sync;
        rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= DIV_RESET;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_nxt;
      if (rx_start) rx_div <= div_eff;
      if (rx_state == RX_IDLE || rx_cnt_clr) rx_cnt <= '0;
      else                                   rx_cnt <= rx_cnt + DIV_WIDTH'(1);
      if (rx_state == RX_START) rx_bit <= '0;
      else if (rx_shift_en)     rx_bit <= rx_bit + 3'd1;
      if (rx_shift_en) rx_shift <= {rx_sync, rx_shift[7:1]};
    end
  end

endmodule

// File: tb/tb_wb_uart_fifo.sv
// Bench for wb_uart_fifo: randomized bytes checked against queue models of both FIFOs and a serial-line decoder.
module tb_wb_uart_fifo;

  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_DIV = 2'd2, A_CTRL = 2'd3;
  localparam int BIT_CLKS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  sel_i = '0;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        tx;
  logic        rx = 1'b1;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_uart_fifo dut (
    .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .we_i(we_i), .sel_i(sel_i),
    .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o), .dat_o(dat_o), .tx(tx), .rx(rx), .irq(irq)
  );

  // Serial-line decoder: samples mid-bit and records byte, stop bit and start cycle.
  logic [7:0] mon_byte[$];
  logic       mon_stop[$];
  int         mon_t0[$];
  int         mt0;
  logic [7:0] mb;

  always begin
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      mt0 = cyc;
      repeat (BIT_CLKS / 2) @(negedge clk);
      if (tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CLKS) @(negedge clk);
          mb[i] = tx;
        end
        repeat (BIT_CLKS) @(negedge clk);
        mon_byte.push_back(mb);
        mon_stop.push_back(tx);
        mon_t0.push_back(mt0);
      end
    end
  end

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] r, output logic ak);
    @(negedge clk);
    adr_i = {12'h000, a, 2'b00};
    dat_i = d;
    we_i  = w;
    sel_i = s;
    stb_i = 1'b1;
    cyc_i = 1'b1;
    @(posedge clk);
    #1;
    ak = ack_o;
    r  = dat_o;
    @(negedge clk);
    stb_i = 1'b0;
    cyc_i = 1'b0;
    we_i  = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic ak;
    bus(1'b1, a, d, 4'hF, r, ak);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] r);
    logic ak;
    bus(1'b0, a, 32'h0, 4'hF, r, ak);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic sb);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = sb;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    logic ak;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %0b want 0", ack_o); end
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %0b want 1", tx); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %0b want 0", irq); end
    vectors++; if (dat_o !== 32'h0) begin miscompares++; $display("FAIL reset_dat_o: got %h want 0", dat_o); end
    rd(A_STATUS, r);
    vectors++; if (r !== 32'h05) begin miscompares++; $display("FAIL reset_status: got %h want 00000005", r); end
    rd(A_DIV, r);
    vectors++; if (r !== 32'd104) begin miscompares++; $display("FAIL reset_div: got %0d want 104", r); end
    bus(1'b1, A_DIV, 32'h1234, 4'b1110, r, ak);
    vectors++; if (ak !== 1'b1) begin miscompares++; $display("FAIL sel0_ack: got %0b want 1", ak); end
    rd(A_DIV, r);
    vectors++; if (r !== 32'd104) begin miscompares++; $display("FAIL sel0_div: got %0d want 104", r); end
  endtask

  task automatic test_tx_single;
    logic [31:0] r;
    logic ak;
    logic [9:0] fb;
    logic found;
    int n;
    wr(A_DIV, BIT_CLKS);
    mon_byte.delete(); mon_stop.delete(); mon_t0.delete();
    fb = {1'b1, 8'h55, 1'b0};
    bus(1'b1, A_DATA, 32'h55, 4'hF, r, ak);
    vectors++; if (ak !== 1'b1) begin miscompares++; $display("FAIL tx_ack: got %0b want 1", ak); end
    @(posedge clk);
    #1;
    vectors++; if (ack_o !== 1'b0) begin miscompares++; $display("FAIL tx_ack_width: got %0b want 0", ack_o); end
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      if (tx === 1'b0) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL tx_start: got no start bit want start within 20 cycles"); end
    if (found) begin
      for (int k = 0; k < 10 * BIT_CLKS; k++) begin
        vectors++;
        if (tx !== fb[k / BIT_CLKS]) begin
          miscompares++; $display("FAIL tx_wave cyc %0d: got %0b want %0b", k, tx, fb[k / BIT_CLKS]);
        end
        if (k < 10 * BIT_CLKS - 1) @(negedge clk);
      end
    end
    rd(A_STATUS, r);
    vectors++; if (r[4] !== 1'b0 || r[2] !== 1'b1) begin miscompares++; $display("FAIL tx_done_status: got %h want busy=0 tx_empty=1", r); end
    vectors++; if (mon_byte.size() !== 1 || mon_byte[0] !== 8'h55) begin
      miscompares++; $display("FAIL tx_decode: got %0d frames want one frame 55", mon_byte.size());
    end
  endtask

  task automatic test_rx_single;
    logic [31:0] r;
    send_rx(8'hA3, 1'b1);
    repeat (6) @(negedge clk);
    rd(A_STATUS, r);
    vectors++; if (r[0] !== 1'b0) begin miscompares++; $display("FAIL rx_not_empty: got rx_empty=%0b want 0", r[0]); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL rx_irq_masked: got %0b want 0", irq); end
    wr(A_CTRL, 32'h1);
    repeat (2) @(negedge clk);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL rx_irq: got %0b want 1", irq); end
    rd(A_DATA, r);
    vectors++; if (r !== 32'h000000A3) begin miscompares++; $display("FAIL rx_data: got %h want 000000a3", r); end
    rd(A_STATUS, r);
    vectors++; if (r[0] !== 1'b1) begin miscompares++; $display("FAIL rx_empty_after: got %0b want 1", r[0]); end
    repeat (2) @(negedge clk);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL rx_irq_clear: got %0b want 0", irq); end
    rd(A_DATA, r);
    vectors++; if (r !== 32'h0) begin miscompares++; $display("FAIL rx_empty_read: got %h want 0", r); end
    wr(A_CTRL, 32'h0);
  endtask

  task automatic test_rx_overflow;
    logic [31:0] r;
    logic [7:0] q[$];
    logic [7:0] b;
    logic ovr;
    ovr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      send_rx(b, 1'b1);
      if (q.size() < 8) q.push_back(b);
      else ovr = 1'b1;
    end
    repeat (6) @(negedge clk);
    rd(A_STATUS, r);
    vectors++; if (r[1] !== (q.size() == 8)) begin miscompares++; $display("FAIL rx_full: got %0b want %0b", r[1], q.size() == 8); end
    vectors++; if (r[5] !== ovr) begin miscompares++; $display("FAIL rxovr_set: got %0b want %0b", r[5], ovr); end
    for (int i = 0; i < 8; i++) begin
      rd(A_DATA, r);
      b = q.pop_front();
      vectors++; if (r !== {24'h0, b}) begin miscompares++; $display("FAIL rx_order %0d: got %h want %h", i, r, b); end
    end
    rd(A_STATUS, r);
    vectors++; if (r[0] !== 1'b1) begin miscompares++; $display("FAIL rx_drained: got rx_empty=%0b want 1", r[0]); end
    wr(A_CTRL, 32'h20);
    rd(A_STATUS, r);
    vectors++; if (r[5] !== 1'b0) begin miscompares++; $display("FAIL rxovr_clear: got %0b want 0", r[5]); end
  endtask

  task automatic test_ferr_glitch;
    logic [31:0] r;
    send_rx(8'h3C, 1'b0);
    repeat (6) @(negedge clk);
    rd(A_STATUS, r);
    vectors++; if (r[6] !== 1'b1) begin miscompares++; $display("FAIL ferr_set: got %0b want 1", r[6]); end
    vectors++; if (r[0] !== 1'b1) begin miscompares++; $display("FAIL ferr_no_push: got rx_empty=%0b want 1", r[0]); end
    wr(A_CTRL, 32'h40);
    rd(A_STATUS, r);
    vectors++; if (r[6] !== 1'b0) begin miscompares++; $display("FAIL ferr_clear: got %0b want 0", r[6]); end
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rd(A_STATUS, r);
    vectors++; if (r[0] !== 1'b1 || r[6] !== 1'b0) begin
      miscompares++; $display("FAIL glitch: got rx_empty=%0b ferr=%0b want 1 0", r[0], r[6]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    logic [7:0] exp[$];
    logic [7:0] b;
    int fifo_cnt;
    int n;
    logic ovf;
    mon_byte.delete(); mon_stop.delete(); mon_t0.delete();
    b = 8'($urandom_range(0, 255));
    wr(A_DATA, {24'h0, b});
    exp.push_back(b);
    repeat (4) @(negedge clk);
    rd(A_STATUS, r);
    vectors++; if (r[4] !== 1'b1) begin miscompares++; $display("FAIL tx_busy: got %0b want 1", r[4]); end
    fifo_cnt = 0;
    ovf = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      wr(A_DATA, {24'h0, b});
      if (fifo_cnt < 8) begin exp.push_back(b); fifo_cnt++; end
      else ovf = 1'b1;
    end
    rd(A_STATUS, r);
    vectors++; if (r[7] !== ovf) begin miscompares++; $display("FAIL txovf_set: got %0b want %0b", r[7], ovf); end
    vectors++; if (r[3] !== 1'b1) begin miscompares++; $display("FAIL tx_full: got %0b want 1", r[3]); end
    n = 0;
    while (mon_byte.size() < exp.size() && n < 700) begin
      @(negedge clk);
      n++;
    end
    vectors++; if (mon_byte.size() !== exp.size()) begin
      miscompares++; $display("FAIL tx_frames: got %0d want %0d", mon_byte.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < mon_byte.size(); i++) begin
      vectors++; if (mon_byte[i] !== exp[i] || mon_stop[i] !== 1'b1) begin
        miscompares++; $display("FAIL tx_byte %0d: got %h stop %0b want %h stop 1", i, mon_byte[i], mon_stop[i], exp[i]);
      end
      if (i > 0) begin
        vectors++; if (mon_t0[i] - mon_t0[i-1] !== 10 * BIT_CLKS) begin
          miscompares++; $display("FAIL tx_gap %0d: got %0d want %0d", i, mon_t0[i] - mon_t0[i-1], 10 * BIT_CLKS);
        end
      end
    end
    repeat (60) @(negedge clk);
    vectors++; if (mon_byte.size() !== exp.size()) begin
      miscompares++; $display("FAIL tx_extra: got %0d frames want %0d", mon_byte.size(), exp.size());
    end
    wr(A_CTRL, 32'h82);
    repeat (2) @(negedge clk);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL tx_irq: got %0b want 1", irq); end
    rd(A_STATUS, r);
    vectors++; if (r[7:0] !== 8'h05) begin miscompares++; $display("FAIL tx_final_status: got %h want 05", r[7:0]); end
    wr(A_CTRL, 32'h0);
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_rx_single();
    test_rx_overflow();
    test_ferr_glitch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion want completion within 50000 cycles");
    $fatal(1, "timeout");
  end

endmodule
